// File: rtl/ps2_key_encoder.sv
// PS/2 serial keyboard stream to 11-bit toggle-style ps2_key event word.
// Optional `PS2_KEY_REPEAT_SUPPRESS_EN drops typematic repeat makes.
module ps2_key_encoder #(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 25000
) (
  input  logic        clk_25,
  input  logic        RESET_L,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        parity_err
);

  localparam int unsigned FW = 8;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned BW = 4;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_clk_d;
  logic          fall_c;

  logic [BW-1:0] bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          frame_done_c, frame_ok_c, is_resp_c;

  logic          ext_f, rel_f, ext_n, rel_n;
  logic [10:0]   key_n;
  logic          perr_n;
`ifdef PS2_KEY_REPEAT_SUPPRESS_EN
  logic [8:0]    last_make, last_n;
`endif

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Pin synchronisers; idle PS/2 lines are high
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Deglitch: filtered clock follows only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall_c = filt_clk_d & ~filt_clk;

  // Frame capture with mid-frame timeout; a sampled fall always beats the timeout
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else if (fall_c) begin
      to_cnt <= '0;
      if (bit_cnt == BW'(0)) begin
        if (!data_s) bit_cnt <= BW'(1);
      end else if (bit_cnt <= BW'(8)) begin
        shreg   <= {data_s, shreg[7:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end else if (bit_cnt == BW'(9)) begin
        par_bit <= data_s;
        bit_cnt <= bit_cnt + BW'(1);
      end else begin
        bit_cnt <= '0;
      end
    end else if (bit_cnt != BW'(0)) begin
      if (to_cnt == TW'(TIMEOUT - 1)) begin
        bit_cnt <= '0;
        shreg   <= '0;
        to_cnt  <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end else begin
      to_cnt <= '0;
    end
  end

  assign frame_done_c = fall_c && (bit_cnt == BW'(10));
  assign frame_ok_c   = data_s && (^{shreg, par_bit});

  always_comb begin
    is_resp_c = 1'b0;
    case (shreg)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_resp_c = 1'b1;
      default:                                  is_resp_c = 1'b0;
    endcase
  end

  // Prefix sequencing and event word formation
  always_comb begin
    ext_n  = ext_f;
    rel_n  = rel_f;
    key_n  = ps2_key;
    perr_n = 1'b0;
`ifdef PS2_KEY_REPEAT_SUPPRESS_EN
    last_n = last_make;
`endif
    if (frame_done_c) begin
      if (!frame_ok_c) begin
        perr_n = 1'b1;
        ext_n  = 1'b0;
        rel_n  = 1'b0;
      end else if (shreg == 8'hE0) begin
        ext_n = 1'b1;
      end else if (shreg == 8'hF0) begin
        rel_n = 1'b1;
      end else if (!(is_resp_c && !ext_f && !rel_f)) begin
        ext_n = 1'b0;
        rel_n = 1'b0;
`ifdef PS2_KEY_REPEAT_SUPPRESS_EN
        if (rel_f) begin
          last_n = '0;
          key_n  = {~ps2_key[10], 1'b0, ext_f, shreg};
        end else if ({ext_f, shreg} != last_make) begin
          last_n = {ext_f, shreg};
          key_n  = {~ps2_key[10], 1'b1, ext_f, shreg};
        end
`else
        key_n = {~ps2_key[10], ~rel_f, ext_f, shreg};
`endif
      end
    end
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      ext_f      <= 1'b0;
      rel_f      <= 1'b0;
      ps2_key    <= '0;
      parity_err <= 1'b0;
`ifdef PS2_KEY_REPEAT_SUPPRESS_EN
      last_make  <= '0;
`endif
    end else begin
      ext_f      <= ext_n;
      rel_f      <= rel_n;
      ps2_key    <= key_n;
      parity_err <= perr_n;
`ifdef PS2_KEY_REPEAT_SUPPRESS_EN
      last_make  <= last_n;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Randomised self-checking bench for ps2_key_encoder against a frame-level key-event model.
module tb_ps2_key_encoder;

  localparam int unsigned FILT   = 8;
  localparam int unsigned TMO    = 400;
  localparam int unsigned HALF   = 20;

  logic        clk_25 = 1'b0;
  logic        RESET_L;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        parity_err;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [10:0] m_key  = '0;
  logic        m_ext  = 1'b0;
  logic        m_rel  = 1'b0;
  logic [8:0]  m_last = '0;
  int          exp_tog  = 0;
  int          exp_perr = 0;

  // observed counts
  int          obs_tog  = 0;
  int          obs_perr = 0;

  ps2_key_encoder #(.FILT_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk_25    (clk_25),
    .RESET_L   (RESET_L),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .parity_err(parity_err)
  );

  always #5 clk_25 = ~clk_25;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every event flips bit 10, parity_err is a single-cycle pulse
  initial begin
    logic [10:0] prev_key;
    logic        prev_perr;
    prev_key  = '0;
    prev_perr = 1'b0;
    forever begin
      @(negedge clk_25);
      if (RESET_L !== 1'b1) begin
        prev_key  = ps2_key;
        prev_perr = 1'b0;
      end else begin
        if (ps2_key !== prev_key) begin
          obs_tog++;
          check("toggle_bit_flip", 32'(ps2_key[10] ^ prev_key[10]), 32'd1);
        end
        if (parity_err === 1'b1) begin
          obs_perr++;
          check("perr_width", 32'(prev_perr), 32'd0);
        end
        prev_key  = ps2_key;
        prev_perr = parity_err;
      end
    end
  end

  // Reference model: apply one complete frame at key-event level
  task automatic model_frame(input logic [7:0] b, input bit ok);
    bit emit;
    if (!ok) begin
      exp_perr++;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (!m_ext && !m_rel &&
                 (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
      emit = 1'b0;
    end else begin
      emit = 1'b1;
`ifdef PS2_KEY_REPEAT_SUPPRESS_EN
      if (m_rel) m_last = '0;
      else if ({m_ext, b} == m_last) emit = 1'b0;
      else m_last = {m_ext, b};
`endif
      if (emit) begin
        m_key = {~m_key[10], ~m_rel, m_ext, b};
        exp_tog++;
      end
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_key  = '0;
    m_ext  = 1'b0;
    m_rel  = 1'b0;
    m_last = '0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_key"},  32'(ps2_key), 32'(m_key));
    check({tag, "_tog"},  32'(obs_tog), 32'(exp_tog));
    check({tag, "_perr"}, 32'(obs_perr), 32'(exp_perr));
  endtask

  // Drive nbits of a frame; truncated frames optionally idle past the timeout
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit wait_to);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk_25);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk_25);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk_25);
    if (nbits == 11) model_frame(b, !bad_par && !bad_stop);
    else if (wait_to) repeat (TMO + 100) @(negedge clk_25);
  endtask

  initial begin
    logic [7:0] pool [9];
    int         tog0;
    logic [7:0] b;
    int         nb;
    pool = '{8'hE0, 8'hF0, 8'hAA, 8'h00, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};

    RESET_L  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk_25);
    check("reset_key",  32'(ps2_key), 32'h0);
    check("reset_perr", 32'(parity_err), 32'h0);
    RESET_L = 1'b1;
    repeat (5) @(negedge clk_25);

    send_frame(8'h1C, 0, 0, 11, 0);
    check("a_make_lit", 32'(ps2_key), 32'h61C);
    check_state("a_make");

    send_frame(8'hE0, 0, 0, 11, 0);
    send_frame(8'hF0, 0, 0, 11, 0);
    send_frame(8'h74, 0, 0, 11, 0);
    check("ext_break_lit", 32'(ps2_key), 32'h174);
    check_state("ext_break");

    send_frame(8'h29, 1, 0, 11, 0);
    check("bad_par_cnt", 32'(obs_perr), 32'd1);
    check_state("bad_par");
    send_frame(8'h29, 0, 0, 11, 0);
    check("good_29_lit", 32'(ps2_key), 32'h629);
    check_state("good_29");

    send_frame(8'h55, 0, 0, 5, 1);
    check_state("trunc");
    send_frame(8'h14, 0, 0, 11, 0);
    check("after_to_lit", 32'(ps2_key), 32'h214);
    check_state("after_to");

    ps2_clk = 1'b0;
    @(negedge clk_25);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk_25);
    check_state("glitch");
    send_frame(8'h1C, 0, 0, 11, 0);
    check_state("post_glitch");

    tog0 = obs_tog;
    for (int i = 0; i < 3; i++) send_frame(8'h3A, 0, 0, 11, 0);
    send_frame(8'hF0, 0, 0, 11, 0);
    send_frame(8'h3A, 0, 0, 11, 0);
`ifdef PS2_KEY_REPEAT_SUPPRESS_EN
    check("repeat_toggles", 32'(obs_tog - tog0), 32'd2);
`else
    check("repeat_toggles", 32'(obs_tog - tog0), 32'd4);
`endif
    check_state("repeat");

    send_frame(8'hAA, 0, 0, 11, 0);
    check_state("resp_aa");

    send_frame(8'h1C, 0, 0, 4, 0);
    #3;
    RESET_L = 1'b0;
    #1;
    check("async_rst_key", 32'(ps2_key), 32'h0);
    model_reset();
    repeat (5) @(negedge clk_25);
    RESET_L = 1'b1;
    repeat (5) @(negedge clk_25);
    send_frame(8'h1C, 0, 0, 11, 0);
    check("post_rst_lit", 32'(ps2_key), 32'h61C);
    check_state("post_rst");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 3) b = pool[$urandom_range(0, 8)];
      else b = 8'($urandom);
      nb = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 10)) : 11;
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, nb, 1);
      check_state("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
